// File: rtl/serial_twos_pkg.sv
// Shared types and sizing helpers for the bit-serial two's-complement negator.
// Latency: n/a. Backpressure: n/a (continuous bit stream, no handshake).
package serial_twos_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Negation state: SCAN passes bits through, INVERT flips them after the first '1'.
  typedef enum logic {
    SCAN   = 1'b0,
    INVERT = 1'b1
  } neg_state_t;

  // Counter width that is never zero, even for degenerate word lengths.
  function automatic int clog2_safe(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/serial_twos_bit_counter.sv
// Bit-position counter within a serial word; clr restarts at bit 0, wraps after the last bit.
// Latency: eff_pos/last are combinational from clr. Backpressure: none, advances every cycle.
module serial_twos_bit_counter
  import serial_twos_pkg::*;
#(
  parameter int  WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = clog2_safe(WIDTH)
) (
  input  logic             t_clk,
  input  logic             r_n,
  input  logic             clr,
  output logic [CNT_W-1:0] eff_pos,
  output logic             last
);

  localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] pos;

  // A clr cycle is itself bit 0, so the restart is visible in the same cycle.
  assign eff_pos = clr ? '0 : pos;
  assign last    = (eff_pos == LAST_POS);

  always_ff @(posedge t_clk or negedge r_n) begin
    if (!r_n) begin
      pos <= '0;
    end else if (last) begin
      pos <= '0;
    end else begin
      pos <= eff_pos + 1'b1;
    end
  end

endmodule

// File: rtl/serial_twos_complementer.sv
// Bit-serial two's-complement negator, LSB first; optional SERIAL_TWOS_OUTPUT_REG_EN registers y/last/ovf.
// Latency: 0 cycles (1 cycle with SERIAL_TWOS_OUTPUT_REG_EN). Backpressure: none, one bit per cycle.
module serial_twos_complementer
  import serial_twos_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic t_clk,
  input  logic r_n,
  input  logic i,
  input  logic clr,
  output logic y,
  output logic last,
  output logic ovf
);

  localparam int CNT_W = clog2_safe(WIDTH);

  neg_state_t       state;
  logic             eff_seen;
  logic             last_c;
  logic             y_c;
  logic             ovf_c;
  logic [CNT_W-1:0] eff_pos;

  serial_twos_bit_counter #(
    .WIDTH(WIDTH)
  ) u_bit_counter (
    .t_clk  (t_clk),
    .r_n    (r_n),
    .clr    (clr),
    .eff_pos(eff_pos),
    .last   (last_c)
  );

  assign eff_seen = clr ? 1'b0 : (state == INVERT);
  assign y_c      = i ^ eff_seen;
  // Most-negative word: the only '1' arrives on the final bit.
  assign ovf_c    = last_c & i & ~eff_seen;

  always_ff @(posedge t_clk or negedge r_n) begin
    if (!r_n) begin
      state <= SCAN;
    end else if (last_c) begin
      state <= SCAN;
    end else if (eff_seen || i) begin
      state <= INVERT;
    end else begin
      state <= SCAN;
    end
  end

`ifdef SERIAL_TWOS_OUTPUT_REG_EN
  always_ff @(posedge t_clk or negedge r_n) begin
    if (!r_n) begin
      y    <= 1'b0;
      last <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      y    <= y_c;
      last <= last_c;
      ovf  <= ovf_c;
    end
  end
`else
  assign y    = y_c;
  assign last = last_c;
  assign ovf  = ovf_c;
`endif

  pos_in_range: assert property (@(posedge t_clk) disable iff (!r_n)
    eff_pos <= CNT_W'(WIDTH - 1));

endmodule

// File: tb/tb_serial_twos_complementer.sv
// Directed self-checking bench for serial_twos_complementer (WIDTH=8).
module tb_serial_twos_complementer;

`ifdef SERIAL_TWOS_OUTPUT_REG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic t_clk = 1'b0;
  logic r_n;
  logic i;
  logic clr;
  logic y;
  logic last;
  logic ovf;

  int n_checks = 0;
  int n_fail   = 0;

  logic cap_y    [0:255];
  logic cap_last [0:255];
  logic cap_ovf  [0:255];
  int   ncap = 0;

  serial_twos_complementer #(.WIDTH(8)) dut (
    .t_clk(t_clk),
    .r_n  (r_n),
    .i    (i),
    .clr  (clr),
    .y    (y),
    .last (last),
    .ovf  (ovf)
  );

  always #5 t_clk = ~t_clk;

  // Called at posedge+1: apply a bit, sample at the negedge, return at the next posedge+1.
  task automatic step(input logic bi, input logic bc);
    i   = bi;
    clr = bc;
    @(negedge t_clk);
    cap_y[ncap]    = y;
    cap_last[ncap] = last;
    cap_ovf[ncap]  = ovf;
    ncap++;
    @(posedge t_clk);
    #1;
  endtask

  task automatic feed_word(input logic [7:0] w, input logic clr_first);
    for (int b = 0; b < 8; b++) step(w[b], (b == 0) ? clr_first : 1'b0);
  endtask

  task automatic pad();
    for (int k = 0; k < LAT; k++) step(1'b0, 1'b0);
  endtask

  // Collect one word of captured outputs as {ovf, last, y} bytes, LSB = bit 0.
  function automatic logic [23:0] grab(input int s);
    logic [7:0] gy, gl, go;
    for (int b = 0; b < 8; b++) begin
      gy[b] = cap_y[s + LAT + b];
      gl[b] = cap_last[s + LAT + b];
      go[b] = cap_ovf[s + LAT + b];
    end
    return {go, gl, gy};
  endfunction

  task automatic test_reset();
    logic exp_y1;
    exp_y1 = (LAT == 0) ? 1'b1 : 1'b0;
    r_n = 1'b0; i = 1'b0; clr = 1'b0;
    #2 i = 1'b1;
    #1;
    n_checks++; if (y !== exp_y1) begin n_fail++; $display("FAIL rst_y_hi got=%b exp=%b", y, exp_y1); end
    n_checks++; if (last !== 1'b0) begin n_fail++; $display("FAIL rst_last got=%b exp=0", last); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL rst_ovf got=%b exp=0", ovf); end
    i = 1'b0;
    #1;
    n_checks++; if (y !== 1'b0) begin n_fail++; $display("FAIL rst_y_lo got=%b exp=0", y); end
    repeat (2) @(posedge t_clk);
    #2 i = 1'b1;
    #1;
    n_checks++; if (y !== exp_y1) begin n_fail++; $display("FAIL rst_y_clocked got=%b exp=%b", y, exp_y1); end
    n_checks++; if (last !== 1'b0) begin n_fail++; $display("FAIL rst_last_clocked got=%b exp=0", last); end
    @(posedge t_clk);
    #1;
    r_n = 1'b1;
  endtask

  // First word straight out of reset, no clr: proves reset leaves pos at bit 0.
  task automatic test_negate();
    logic [23:0] g;
    int s;
    s = ncap;
    feed_word(8'h34, 1'b0);
    pad();
    g = grab(s);
    n_checks++; if (g[7:0] !== 8'hCC) begin n_fail++; $display("FAIL neg34_y got=%h exp=cc", g[7:0]); end
    n_checks++; if (g[15:8] !== 8'h80) begin n_fail++; $display("FAIL neg34_last got=%h exp=80", g[15:8]); end
    n_checks++; if (g[23:16] !== 8'h00) begin n_fail++; $display("FAIL neg34_ovf got=%h exp=00", g[23:16]); end
  endtask

  task automatic test_back_to_back();
    logic [23:0] g0, g1;
    int s;
    s = ncap;
    feed_word(8'h01, 1'b1);
    feed_word(8'h00, 1'b0);
    pad();
    g0 = grab(s);
    g1 = grab(s + 8);
    n_checks++; if (g0[7:0] !== 8'hFF) begin n_fail++; $display("FAIL b2b_w0_y got=%h exp=ff", g0[7:0]); end
    n_checks++; if (g1[7:0] !== 8'h00) begin n_fail++; $display("FAIL b2b_w1_y got=%h exp=00", g1[7:0]); end
    n_checks++; if (g1[15:8] !== 8'h80) begin n_fail++; $display("FAIL b2b_w1_last got=%h exp=80", g1[15:8]); end
  endtask

  task automatic test_ovf();
    logic [23:0] g0, g1;
    int s;
    s = ncap;
    feed_word(8'h80, 1'b1);
    feed_word(8'h00, 1'b0);
    pad();
    g0 = grab(s);
    g1 = grab(s + 8);
    n_checks++; if (g0[7:0] !== 8'h80) begin n_fail++; $display("FAIL ovf80_y got=%h exp=80", g0[7:0]); end
    n_checks++; if (g0[23:16] !== 8'h80) begin n_fail++; $display("FAIL ovf80_ovf got=%h exp=80", g0[23:16]); end
    n_checks++; if (g1[23:16] !== 8'h00) begin n_fail++; $display("FAIL ovf00_ovf got=%h exp=00", g1[23:16]); end
    n_checks++; if (g1[7:0] !== 8'h00) begin n_fail++; $display("FAIL ovf00_y got=%h exp=00", g1[7:0]); end
  endtask

  // Three bits of a word (with seen_one set), then clr on what would be bit 3.
  task automatic test_clr_mid_word();
    logic [23:0] g;
    int s;
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    s = ncap;
    feed_word(8'h02, 1'b1);
    pad();
    g = grab(s);
    n_checks++; if (g[7:0] !== 8'hFE) begin n_fail++; $display("FAIL clr_y got=%h exp=fe", g[7:0]); end
    n_checks++; if (g[15:8] !== 8'h80) begin n_fail++; $display("FAIL clr_last got=%h exp=80", g[15:8]); end
    n_checks++; if (g[23:16] !== 8'h00) begin n_fail++; $display("FAIL clr_ovf got=%h exp=00", g[23:16]); end
  endtask

  task automatic test_reset_mid_word();
    logic [23:0] g;
    logic exp_y1;
    int s;
    exp_y1 = (LAT == 0) ? 1'b1 : 1'b0;
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    r_n = 1'b0; i = 1'b1; clr = 1'b0;
    #1;
    n_checks++; if (y !== exp_y1) begin n_fail++; $display("FAIL midrst_y got=%b exp=%b", y, exp_y1); end
    n_checks++; if (last !== 1'b0) begin n_fail++; $display("FAIL midrst_last got=%b exp=0", last); end
    #1 r_n = 1'b1;
    s = ncap;
    feed_word(8'h05, 1'b0);
    pad();
    g = grab(s);
    n_checks++; if (g[7:0] !== 8'hFB) begin n_fail++; $display("FAIL midrst_word_y got=%h exp=fb", g[7:0]); end
    n_checks++; if (g[15:8] !== 8'h80) begin n_fail++; $display("FAIL midrst_word_last got=%h exp=80", g[15:8]); end
  endtask

  initial begin
    test_reset();
    test_negate();
    test_back_to_back();
    test_ovf();
    test_clr_mid_word();
    test_reset_mid_word();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
